// File: rtl/game_pkg.sv
// Shared definitions for the match clock: game FSM state codes, the display
// blank code and the saturation ceiling helper.
package game_pkg;

    // Game FSM states driven by the top-level game controller (6 and 7 unused).
    typedef enum logic [2:0] {
        MENU  = 3'd0,
        GAME  = 3'd1,
        P1WIN = 3'd2,
        P2WIN = 3'd3,
        TIE   = 3'd4,
        POINT = 3'd5
    } game_state_e;

    // Shift-add-3 converter sequencing.
    typedef enum logic {
        CONV_IDLE,
        CONV_SHIFT
    } conv_state_e;

    // Digit code the seven-segment driver renders as an unlit digit.
    localparam logic [3:0] BLANK_DIGIT = 4'hA;

    // Largest count both representable in binary and displayable in decimal.
    function automatic int unsigned max_count(input int unsigned width,
                                              input int unsigned digits);
        int unsigned bin_max;
        int unsigned dec_max;
        bin_max = (32'd1 << width) - 32'd1;
        dec_max = 32'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            dec_max = dec_max * 32'd10;
        end
        dec_max = dec_max - 32'd1;
        return (bin_max < dec_max) ? bin_max : dec_max;
    endfunction

endpackage

// File: rtl/bin2bcd.sv
// Sequential binary-to-BCD converter (shift-add-3). One snapshot cycle plus
// WIDTH shift cycles per conversion; restarts immediately while start is high.
module bin2bcd
    import game_pkg::*;
#(
    parameter int WIDTH  = 7,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      bin,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int ITER_W = $clog2(WIDTH + 1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(WIDTH - 1);

    conv_state_e          state_q, state_d;
    logic [WIDTH-1:0]     bin_q, bin_d;
    logic [4*DIGITS-1:0]  acc_q, acc_d;
    logic [4*DIGITS-1:0]  bcd_q, bcd_d;
    logic [4*DIGITS-1:0]  adj;
    logic [ITER_W-1:0]    iter_q, iter_d;
    logic                 done_q, done_d;

    // Add 3 to every digit that is 5 or more before the next left shift.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Sequencer: snapshot, WIDTH shift steps, latch result, back to snapshot.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        iter_d  = iter_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        case (state_q)
            CONV_IDLE: begin
                if (start) begin
                    bin_d   = bin;
                    acc_d   = '0;
                    iter_d  = '0;
                    state_d = CONV_SHIFT;
                end
            end
            CONV_SHIFT: begin
                acc_d  = {adj[4*DIGITS-2:0], bin_q[WIDTH-1]};
                bin_d  = {bin_q[WIDTH-2:0], 1'b0};
                iter_d = iter_q + 1'b1;
                if (iter_q == ITER_LAST) begin
                    bcd_d   = acc_d;
                    done_d  = 1'b1;
                    state_d = CONV_IDLE;
                end
            end
            default: state_d = CONV_IDLE;
        endcase
    end

    // Converter state registers; reset leaves it idle so it restarts on release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CONV_IDLE;
            bin_q   <= '0;
            acc_q   <= '0;
            iter_q  <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            iter_q  <= iter_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == CONV_SHIFT);
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/game_countdown.sv
// Match-clock countdown: tick prescaler, saturating count with bonus time,
// low-time warning, expiry pulse and a blanked BCD display feed.
module game_countdown
    import game_pkg::*;
#(
    parameter int TICK_DIV  = 100_000_000,
    parameter int WIDTH     = 7,
    parameter int DIGITS    = 2,
    parameter int GAME_TIME = 60,
    parameter int WARN_TIME = 10,
    parameter int BONUS     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            state,
    input  logic                  pause,
    input  logic                  bonus,
    output logic [WIDTH-1:0]      count,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  warn,
    output logic                  time_up
);

    localparam int                   MAXV      = int'(max_count(WIDTH, DIGITS));
    localparam int                   DIV_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0]     DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0]     LOAD_VAL  = WIDTH'(GAME_TIME);
    localparam logic [4*DIGITS-1:0]  BLANK_ALL = {DIGITS{BLANK_DIGIT}};

    logic [DIV_W-1:0]     div_q, div_d;
    logic [WIDTH-1:0]     count_q, count_d;
    logic                 warn_q, warn_d;
    logic                 time_up_q, time_up_d;
    logic [4*DIGITS-1:0]  bcd_q, bcd_d;
    logic                 conv_valid_q, conv_valid_d;
    logic [4*DIGITS-1:0]  conv_bcd;
    logic                 conv_busy, conv_done;
    logic                 in_game, running, tick, add_bonus;
    logic [31:0]          sum;

    assign in_game   = (state == GAME);
    assign running   = in_game && !pause && (count_q != '0);
    assign tick      = running && (div_q == DIV_LAST);
    assign add_bonus = in_game && bonus && (count_q != '0);

    // Divider and count: load outside GAME, hold in undefined states, saturate in GAME.
    always_comb begin
        div_d   = div_q;
        count_d = count_q;
        sum     = '0;
        if (in_game) begin
            if (running) begin
                div_d = tick ? '0 : div_q + 1'b1;
            end
            sum     = 32'(count_q) + (add_bonus ? 32'(BONUS) : 32'd0) - (tick ? 32'd1 : 32'd0);
            count_d = (sum > 32'(MAXV)) ? WIDTH'(MAXV) : WIDTH'(sum);
        end else if (state <= POINT) begin
            div_d   = '0;
            count_d = LOAD_VAL;
        end
    end

    // Flags and display, all aligned with the registered count value.
    always_comb begin
        time_up_d    = in_game && (count_q == WIDTH'(1)) && (count_d == '0);
        warn_d       = in_game && (count_d != '0) && (32'(count_d) <= 32'(WARN_TIME));
        conv_valid_d = conv_valid_q | (conv_done & ~conv_busy);
        bcd_d        = (in_game && conv_valid_q) ? conv_bcd : BLANK_ALL;
    end

    // State registers; an asynchronous reset reloads the match time immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q        <= '0;
            count_q      <= LOAD_VAL;
            warn_q       <= 1'b0;
            time_up_q    <= 1'b0;
            bcd_q        <= BLANK_ALL;
            conv_valid_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            count_q      <= count_d;
            warn_q       <= warn_d;
            time_up_q    <= time_up_d;
            bcd_q        <= bcd_d;
            conv_valid_q <= conv_valid_d;
        end
    end

    bin2bcd #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .bin   (count_q),
        .start (1'b1),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    assign count   = count_q;
    assign bcd     = bcd_q;
    assign warn    = warn_q;
    assign time_up = time_up_q;

endmodule

// File: doc/game_countdown.md
# game_countdown

Parametrised countdown for the match clock. It replaces the fixed 60-count, 2-digit timer with a configurable tick prescaler, duration, digit count, pause, bonus time, low-time warning and an expiry pulse. Driven by the top-level game FSM `state`; the `bcd` output feeds the seven-segment display driver. BCD conversion is sequential (shift-add-3), not divide/modulo.

## Interface
- `TICK_DIV`, 100_000_000: clk cycles per count decrement; 1 = every cycle
- `WIDTH`, 7: binary count width
- `DIGITS`, 2: BCD digits on `bcd`
- `GAME_TIME`, 60: load value; must be ≤ MAXV
- `WARN_TIME`, 10: warning threshold
- `BONUS`, 5: amount added per `bonus` pulse
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `state`  in  3  game FSM state: MENU=0, GAME=1, P1WIN=2, P2WIN=3, TIE=4, POINT=5; 6 and 7 are undefined
- `pause`  in  1  level; freezes counting in GAME
- `bonus`  in  1  single-cycle pulse; add BONUS
- `count`  out  WIDTH  registered binary remaining time
- `bcd`  out  4*DIGITS  digit i at [4i+3:4i], i=0 is least significant
- `warn`  out  1  registered low-time flag
- `time_up`  out  1  one-cycle pulse at expiry

## Operation
- MAXV = min(2^WIDTH−1, 10^DIGITS−1). All count arithmetic saturates to [0, MAXV].
- States MENU, P1WIN, P2WIN, TIE and POINT:
  - count ← GAME_TIME, divider ← 0.
  - bonus and pause are ignored.
- Undefined states 6 and 7: count, divider and converter hold their values. Outputs blank as for any non-GAME state.
- GAME, divider behaviour:
  - Divider counts 0..TICK_DIV−1 while !pause && count≠0.
  - tick = divider==TICK_DIV−1; divider wraps to 0 on tick.
  - pause freezes the divider without clearing it.
- GAME, count update:
  - tick only: count−1.
  - bonus only, with count>0: count+BONUS, saturated.
  - tick and bonus in the same cycle: count−1+BONUS, saturated.
  - bonus with count==0: ignored. A game never restarts from 0 inside GAME.
- time_up:
  - Registered. Asserted in the cycle where count first shows 0 after a 1→0 decrement.
  - Exactly one pulse per expiry.
  - Never asserted by load or reset.
- warn: registered; 1 when state==GAME && 0 < count ≤ WARN_TIME, else 0.
- BCD conversion is free-running in sub-module `bin2bcd`:
  - Snapshots count, runs WIDTH shift-add-3 iterations, latches the result, then immediately re-snapshots.
- bcd output (registered):
  - state≠GAME: every digit = 4'hA (blank code).
  - state==GAME: latest converted value, leading zeros shown.

## Timing
- Reset values: count=GAME_TIME, divider=0, bcd all 4'hA, warn=0, time_up=0, converter idle and restarts on release.
- Reset mid-game aborts everything; count reloads on the asynchronous assert.
- count: updates on the clock edge after tick/bonus.
- warn and time_up: valid in the same cycle as the count value they describe.
- Conversion period is WIDTH+1 cycles. bcd reflects a count value within 2·(WIDTH+1)+1 cycles of that value appearing.
- On a GAME→other transition, bcd blanks one cycle later.
- On entry to GAME, count=GAME_TIME is already loaded. The first decrement happens TICK_DIV cycles after entry.
- With TICK_DIV=1, count changes faster than conversion. bcd then shows a stale but valid snapshot; this is legal.

## Structure
- Shared package `game_pkg`:
  - state encodings MENU..POINT
  - blank digit constant 4'hA
- Sub-module `bin2bcd`, parameters WIDTH and DIGITS:
  - ports: clk, rst, bin, start, busy, done, bcd.
  - `game_countdown` holds start high continuously.
- Top-level contents: divider, count, warn/time_up logic and the output blanking register.

## Test plan
- Reset, then MENU: count=60, bcd=AA, warn=0, time_up=0.
- Defaults with TICK_DIV=4, GAME for 240 cycles:
  - count steps 60→0, one per 4 cycles.
  - warn rises when count=10.
  - single time_up pulse with count=0; bcd settles to 00.
  - count stays 0, no second pulse.
- TICK_DIV=4, pause for 10 cycles mid-count: count and divider frozen; the decrement resumes exactly where the divider left off.
- bonus timing:
  - bonus at count=58 gives 63.
  - bonus coincident with a tick at 58 gives 62.
  - DIGITS=2, count=97, bonus gives 99 (saturated).
- bonus at count=0, and bonus in MENU: no change.
- state GAME→TIE mid-count, then →GAME: count reloads to 60, bcd blanks and returns showing 60. State 7 mid-count: count holds, bcd=AA.
- WIDTH=10, DIGITS=3, GAME_TIME=999: bcd = 9,9,9 after conversion latency. Assert rst low mid-conversion: all outputs at reset values immediately.
